// File: rtl/kernel_kcore_hls_dl_pkg.sv
// rtl/kernel_kcore_hls_dl_pkg.sv - shared deadlock-confirm state encodings and widths
// Contents: dl_state_t, DL_IDLE/DL_SUSPECT/DL_CONFIRMED encodings, DL_STATS_W.
package kernel_kcore_hls_dl_pkg;

    typedef logic [1:0] dl_state_t;

    localparam dl_state_t DL_IDLE      = 2'd0;
    localparam dl_state_t DL_SUSPECT   = 2'd1;
    localparam dl_state_t DL_CONFIRMED = 2'd2;

    localparam int DL_STATS_W = 16;

endpackage

// File: rtl/kernel_kcore_hls_dl_dep_merge.sv
// rtl/kernel_kcore_hls_dl_dep_merge.sv - OR-merge of valid input dependency slices
// Ports:
//   dep_vld_vec  in  [IN_CHAN_NUM]          per-channel dependency valid
//   dep_data_vec in  [IN_CHAN_NUM*PROC_NUM] channel i at [i*PROC_NUM +: PROC_NUM]
//   merged       out [PROC_NUM]             OR of all valid slices
module kernel_kcore_hls_dl_dep_merge #(
    parameter int PROC_NUM    = 4,
    parameter int IN_CHAN_NUM = 2
) (
    input  logic [IN_CHAN_NUM-1:0]          dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] dep_data_vec,
    output logic [PROC_NUM-1:0]             merged
);

    always_comb begin
        merged = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            merged = merged | ({PROC_NUM{dep_vld_vec[i]}} & dep_data_vec[i*PROC_NUM +: PROC_NUM]);
        end
    end

endmodule

// File: rtl/kernel_kcore_hls_deadlock_confirm_unit.sv
// rtl/kernel_kcore_hls_deadlock_confirm_unit.sv - debounced self-dependency deadlock detector
// Optional feature: define KERNEL_KCORE_DL_STATS_EN to get a saturating count of
// confirmed deadlock events on dl_event_cnt (constant 0 otherwise).
// Ports:
//   clock, reset (async, active-high)
//   proc_dep_vld_vec     in  [OUT_CHAN_NUM]          process blocked on output channel i
//   in_chan_dep_vld_vec  in  [IN_CHAN_NUM]           input channel dependency valid
//   in_chan_dep_data_vec in  [IN_CHAN_NUM*PROC_NUM]  input channel dependency data
//   token_in_vec         in  [IN_CHAN_NUM]           incoming report tokens
//   dl_detect_in, origin, token_clear                global detect / originator / ack
//   out_chan_dep_vld_vec out [OUT_CHAN_NUM]          pass-through of proc_dep_vld_vec
//   out_chan_dep_data    out [PROC_NUM]              dep_reg with own bit set
//   token_out_vec        out [OUT_CHAN_NUM]          registered outgoing tokens
//   dl_detect_out        out                         registered, high in CONFIRMED
//   dl_state             out [2]                     FSM state
//   dl_event_cnt         out [16]                    confirmed-event count
module kernel_kcore_hls_deadlock_confirm_unit
    import kernel_kcore_hls_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [1:0]                      dl_state,
    output logic [DL_STATS_W-1:0]           dl_event_cnt
);

    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit SINGLE_CYCLE = (CONFIRM_CYCLES == 1);
    localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

    logic [PROC_NUM-1:0] dep_reg;
    logic [PROC_NUM-1:0] dep_next;
    logic [PROC_NUM-1:0] merged;
    logic                gate;
    logic                blocked;
    logic                raw;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    dl_state_t           state;
    dl_state_t           state_next;

    kernel_kcore_hls_dl_dep_merge #(
        .PROC_NUM    (PROC_NUM),
        .IN_CHAN_NUM (IN_CHAN_NUM)
    ) u_dep_merge (
        .dep_vld_vec  (in_chan_dep_vld_vec),
        .dep_data_vec (in_chan_dep_data_vec),
        .merged       (merged)
    );

    // Once a deadlock is flagged globally, freeze the dependency view until
    // a report token arrives so the snapshot stays consistent.
    assign gate     = ~dl_detect_in | (|token_in_vec);
    assign blocked  = |proc_dep_vld_vec;
    assign dep_next = gate ? merged : dep_reg;
    assign raw      = gate & dep_next[PROC_ID] & blocked;

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg | SELF_BIT;
    assign dl_state             = state;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            DL_IDLE: begin
                if (raw) begin
                    if (SINGLE_CYCLE) begin
                        state_next = DL_CONFIRMED;
                        cnt_next   = '0;
                    end else begin
                        state_next = DL_SUSPECT;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            DL_SUSPECT: begin
                if (!raw) begin
                    state_next = DL_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = DL_CONFIRMED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            DL_CONFIRMED: begin
                // Acknowledge wins over a still-high raw; re-arming starts next cycle.
                if (token_clear || !raw) begin
                    state_next = DL_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = DL_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dep_reg       <= '0;
            cnt           <= '0;
            state         <= DL_IDLE;
            dl_detect_out <= 1'b0;
            token_out_vec <= '0;
        end else begin
            dep_reg       <= blocked ? dep_next : '0;
            cnt           <= cnt_next;
            state         <= state_next;
            dl_detect_out <= (state_next == DL_CONFIRMED);
            // The originator always forwards, even while an ack is in flight.
            token_out_vec <= (((|token_in_vec) & ~token_clear) | origin) ? proc_dep_vld_vec : '0;
        end
    end

`ifdef KERNEL_KCORE_DL_STATS_EN
    logic [DL_STATS_W-1:0] event_cnt;
    logic                  enter_confirmed;

    assign enter_confirmed = (state != DL_CONFIRMED) && (state_next == DL_CONFIRMED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            event_cnt <= '0;
        end else if (enter_confirmed && (event_cnt != {DL_STATS_W{1'b1}})) begin
            event_cnt <= event_cnt + 1'b1;
        end
    end

    assign dl_event_cnt = event_cnt;
`else
    assign dl_event_cnt = '0;
`endif

endmodule

// File: tb/tb_kernel_kcore_hls_deadlock_confirm_unit.sv
// tb/tb_kernel_kcore_hls_deadlock_confirm_unit.sv - directed bench for the deadlock confirm unit
module tb_kernel_kcore_hls_deadlock_confirm_unit;

    localparam int PROC_NUM       = 4;
    localparam int PROC_ID        = 1;
    localparam int IN_CHAN_NUM    = 2;
    localparam int OUT_CHAN_NUM   = 3;
    localparam int CONFIRM_CYCLES = 4;

`ifdef KERNEL_KCORE_DL_STATS_EN
    localparam logic [15:0] EV_AFTER_ONE = 16'd1;
`else
    localparam logic [15:0] EV_AFTER_ONE = 16'd0;
`endif

    logic                            clock;
    logic                            reset;
    logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec;
    logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec;
    logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
    logic [IN_CHAN_NUM-1:0]          token_in_vec;
    logic                            dl_detect_in;
    logic                            origin;
    logic                            token_clear;
    logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec;
    logic [PROC_NUM-1:0]             out_chan_dep_data;
    logic [OUT_CHAN_NUM-1:0]         token_out_vec;
    logic                            dl_detect_out;
    logic [1:0]                      dl_state;
    logic [15:0]                     dl_event_cnt;

    int checks = 0;
    int errors = 0;

    kernel_kcore_hls_deadlock_confirm_unit #(
        .PROC_NUM       (PROC_NUM),
        .PROC_ID        (PROC_ID),
        .IN_CHAN_NUM    (IN_CHAN_NUM),
        .OUT_CHAN_NUM   (OUT_CHAN_NUM),
        .CONFIRM_CYCLES (CONFIRM_CYCLES)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .proc_dep_vld_vec     (proc_dep_vld_vec),
        .in_chan_dep_vld_vec  (in_chan_dep_vld_vec),
        .in_chan_dep_data_vec (in_chan_dep_data_vec),
        .token_in_vec         (token_in_vec),
        .dl_detect_in         (dl_detect_in),
        .origin               (origin),
        .token_clear          (token_clear),
        .out_chan_dep_vld_vec (out_chan_dep_vld_vec),
        .out_chan_dep_data    (out_chan_dep_data),
        .token_out_vec        (token_out_vec),
        .dl_detect_out        (dl_detect_out),
        .dl_state             (dl_state),
        .dl_event_cnt         (dl_event_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic raw_stim();
        proc_dep_vld_vec     = 3'b001;
        in_chan_dep_vld_vec  = 2'b01;
        in_chan_dep_data_vec = 8'b0000_0010;
        dl_detect_in         = 1'b0;
        token_in_vec         = 2'b00;
        token_clear          = 1'b0;
        origin               = 1'b0;
    endtask

    initial begin
        // Reset with random inputs
        reset                = 1'b1;
        proc_dep_vld_vec     = 3'($urandom);
        in_chan_dep_vld_vec  = 2'($urandom);
        in_chan_dep_data_vec = 8'($urandom);
        token_in_vec         = 2'($urandom);
        dl_detect_in         = 1'($urandom);
        origin               = 1'($urandom);
        token_clear          = 1'($urandom);
        tick();
        tick();
        tick();
        check("rst_state", 32'(dl_state), 32'd0);
        check("rst_detect", 32'(dl_detect_out), 32'd0);
        check("rst_token", 32'(token_out_vec), 32'd0);
        check("rst_event", 32'(dl_event_cnt), 32'd0);
        check("rst_data", 32'(out_chan_dep_data), 32'b0010);
        check("rst_vld_pass", 32'(out_chan_dep_vld_vec), 32'(proc_dep_vld_vec));

        raw_stim();
        in_chan_dep_vld_vec = 2'b00;
        proc_dep_vld_vec    = 3'b000;
        reset = 1'b0;
        tick();
        check("idle_state", 32'(dl_state), 32'd0);

        // Confirm after CONFIRM_CYCLES of raw
        raw_stim();
        tick();
        check("c1_state", 32'(dl_state), 32'd1);
        check("c1_cnt", 32'(dut.cnt), 32'd1);
        tick();
        check("c2_cnt", 32'(dut.cnt), 32'd2);
        check("c2_detect", 32'(dl_detect_out), 32'd0);
        tick();
        check("c3_cnt", 32'(dut.cnt), 32'd3);
        check("c3_detect", 32'(dl_detect_out), 32'd0);
        tick();
        check("c4_state", 32'(dl_state), 32'd2);
        check("c4_detect", 32'(dl_detect_out), 32'd1);
        check("c4_event", 32'(dl_event_cnt), 32'(EV_AFTER_ONE));
        check("c4_data", 32'(out_chan_dep_data), 32'b0010);

        // token_clear beats a still-high raw
        token_clear = 1'b1;
        tick();
        check("clr_state", 32'(dl_state), 32'd0);
        check("clr_cnt", 32'(dut.cnt), 32'd0);
        check("clr_detect", 32'(dl_detect_out), 32'd0);
        token_clear = 1'b0;
        tick();
        check("rearm_state", 32'(dl_state), 32'd1);
        in_chan_dep_vld_vec = 2'b00;
        tick();
        check("drop_state", 32'(dl_state), 32'd0);

        // Raw for only 3 cycles never confirms
        raw_stim();
        tick();
        check("s1_state", 32'(dl_state), 32'd1);
        tick();
        tick();
        check("s3_state", 32'(dl_state), 32'd1);
        check("s3_detect", 32'(dl_detect_out), 32'd0);
        in_chan_dep_vld_vec = 2'b00;
        tick();
        check("s4_state", 32'(dl_state), 32'd0);
        check("s4_detect", 32'(dl_detect_out), 32'd0);
        check("s4_data", 32'(out_chan_dep_data), 32'b0010);
        check("s4_event", 32'(dl_event_cnt), 32'(EV_AFTER_ONE));

        // Asynchronous reset in CONFIRMED, then counting restarts
        raw_stim();
        tick();
        tick();
        tick();
        tick();
        check("ar_pre_state", 32'(dl_state), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", 32'(dl_state), 32'd0);
        check("ar_detect", 32'(dl_detect_out), 32'd0);
        check("ar_event", 32'(dl_event_cnt), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_restart_state", 32'(dl_state), 32'd1);
        check("ar_restart_cnt", 32'(dut.cnt), 32'd1);
        in_chan_dep_vld_vec = 2'b00;
        tick();

        // Gate closed by dl_detect_in holds dep_reg
        in_chan_dep_vld_vec  = 2'b01;
        in_chan_dep_data_vec = 8'b0000_0100;
        tick();
        check("g_load_data", 32'(out_chan_dep_data), 32'b0110);
        check("g_load_state", 32'(dl_state), 32'd0);
        dl_detect_in         = 1'b1;
        in_chan_dep_data_vec = 8'b0000_0010;
        tick();
        check("g_hold_data", 32'(out_chan_dep_data), 32'b0110);
        check("g_hold_state", 32'(dl_state), 32'd0);
        check("g_hold_token", 32'(token_out_vec), 32'd0);
        token_in_vec     = 2'b10;
        proc_dep_vld_vec = 3'b011;
        #1;
        check("g_vld_pass", 32'(out_chan_dep_vld_vec), 32'b011);
        tick();
        check("g_token_fwd", 32'(token_out_vec), 32'b011);
        check("g_open_data", 32'(out_chan_dep_data), 32'b0010);
        check("g_open_state", 32'(dl_state), 32'd1);

        // Token forwarding: clear blocks, origin overrides clear
        token_in_vec     = 2'b01;
        token_clear      = 1'b1;
        origin           = 1'b0;
        proc_dep_vld_vec = 3'b110;
        tick();
        check("tk_clear_block", 32'(token_out_vec), 32'd0);
        origin = 1'b1;
        tick();
        check("tk_origin", 32'(token_out_vec), 32'b110);
        origin       = 1'b0;
        token_clear  = 1'b0;
        token_in_vec = 2'b00;
        tick();
        check("tk_none", 32'(token_out_vec), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_kcore_hls_deadlock_confirm_unit.md
KERNEL_KCORE_HLS_DEADLOCK_CONFIRM_UNIT -- requirements
Module: kernel_kcore_hls_deadlock_confirm_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4: number of processes, and the width of the dependency vector.
REQ-002 SHALL have parameter PROC_ID, default 0: index of the owning process, range 0..PROC_NUM-1.
REQ-003 SHALL have parameter IN_CHAN_NUM, default 2: number of input dependency channels, at least 1.
REQ-004 SHALL have parameter OUT_CHAN_NUM, default 3: number of output dependency channels, at least 1.
REQ-005 SHALL have parameter CONFIRM_CYCLES, default 4: number of consecutive raw self-dependency cycles needed before a deadlock is reported, at least 1.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port proc_dep_vld_vec, input, OUT_CHAN_NUM bits: the process is blocked on output channel i.
REQ-009 SHALL have port in_chan_dep_vld_vec, input, IN_CHAN_NUM bits: input channel dependency-valid flags.
REQ-010 SHALL have port in_chan_dep_data_vec, input, IN_CHAN_NUM*PROC_NUM bits: dependency data, channel i in bit slice [i*PROC_NUM +: PROC_NUM].
REQ-011 SHALL have port token_in_vec, input, IN_CHAN_NUM bits: incoming report tokens.
REQ-012 SHALL have port dl_detect_in, input, 1 bit: a deadlock has been detected globally.
REQ-013 SHALL have port origin, input, 1 bit: this unit originates the token.
REQ-014 SHALL have port token_clear, input, 1 bit: the report has been acknowledged; clears the confirmed state.
REQ-015 SHALL have port out_chan_dep_vld_vec, output, OUT_CHAN_NUM bits: equal to proc_dep_vld_vec, combinationally.
REQ-016 SHALL have port out_chan_dep_data, output, PROC_NUM bits: dep_reg OR one-hot(PROC_ID).
REQ-017 SHALL have port token_out_vec, output, OUT_CHAN_NUM bits, registered: outgoing tokens.
REQ-018 SHALL have port dl_detect_out, output, 1 bit, registered: high while in state CONFIRMED.
REQ-019 SHALL have port dl_state, output, 2 bits, registered: the FSM state.
REQ-020 SHALL have port dl_event_cnt, output, 16 bits: the count of confirmed deadlock events (see REQ-033).

Function
REQ-021 SHALL compute gate = ~dl_detect_in | (|token_in_vec).
REQ-022 SHALL compute merged as the OR, over all i, of ({PROC_NUM{in_chan_dep_vld_vec[i]}} & slice i).
REQ-023 SHALL compute dep_next = gate ? merged : dep_reg.
REQ-024 SHALL update dep_reg each cycle to dep_next when |proc_dep_vld_vec is 1, and to 0 otherwise.
REQ-025 SHALL compute raw = gate & dep_next[PROC_ID] & (|proc_dep_vld_vec).
REQ-026 SHALL implement FSM states IDLE=0, SUSPECT=1 and CONFIRMED=2, with a consecutive-cycle counter cnt of width $clog2(CONFIRM_CYCLES+1).
REQ-027 SHALL, in IDLE: on raw, go to CONFIRMED if CONFIRM_CYCLES==1, otherwise go to SUSPECT with cnt=1; with raw low, stay in IDLE.
REQ-028 SHALL, in SUSPECT: on raw with cnt==CONFIRM_CYCLES-1, go to CONFIRMED; on raw otherwise, increment cnt; with raw low, go to IDLE with cnt=0.
REQ-029 SHALL, in CONFIRMED: on token_clear or raw low, go to IDLE with cnt=0; otherwise hold; token_clear SHALL take priority over raw, with no re-entry into SUSPECT in the same cycle.
REQ-030 SHALL have latency such that, with raw first high in cycle t and held high, dl_detect_out is 1 from cycle t+CONFIRM_CYCLES.
REQ-031 SHALL update token_out_vec each cycle to proc_dep_vld_vec when ((|token_in_vec & ~token_clear) | origin), and to 0 otherwise; origin SHALL override token_clear.

Reset
REQ-032 SHALL, while reset=1 and regardless of clock: set dep_reg, cnt, token_out_vec, dl_detect_out and dl_event_cnt to 0, and dl_state to IDLE; reset asserted mid-SUSPECT or mid-CONFIRMED SHALL abort to IDLE, and counting SHALL restart from 0 after release.

Configuration
REQ-033 SHALL gate the event counter with macro KERNEL_KCORE_DL_STATS_EN: when defined, dl_event_cnt SHALL increment by 1 on each transition into CONFIRMED and saturate at 16'hFFFF; when undefined, dl_event_cnt SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-034 SHALL take the state encodings (DL_IDLE, DL_SUSPECT, DL_CONFIRMED) and DL_STATS_W=16 from the shared package kernel_kcore_hls_dl_pkg.
REQ-035 SHALL implement the combinational dependency merge of REQ-022 as the sub-module kernel_kcore_hls_dl_dep_merge, with parameters PROC_NUM and IN_CHAN_NUM.

Verification (PROC_NUM=4, PROC_ID=1, IN_CHAN_NUM=2, OUT_CHAN_NUM=3, CONFIRM_CYCLES=4)
REQ-036 SHALL cover: reset=1 with random inputs -> all outputs 0 (out_chan_dep_data=4'b0010) and dl_state=0.
REQ-037 SHALL cover: proc_dep_vld_vec=3'b001, in_chan_dep_vld_vec=2'b01, slice0=4'b0010, dl_detect_in=0 for 4 cycles from t -> dl_detect_out=1 at t+4, dl_state=2, dl_event_cnt=1 (macro defined).
REQ-038 SHALL cover: the same stimulus held for 3 cycles then in_chan_dep_vld_vec=0 -> dl_state goes 1 then 0, dl_detect_out never 1.
REQ-039 SHALL cover: in CONFIRMED, assert token_clear=1 with raw still high -> next cycle dl_state=0 and cnt=0, then SUSPECT the cycle after.
REQ-040 SHALL cover: dl_detect_in=1, token_in_vec=0, dep_reg=4'b0100 with new data 4'b0010 -> dep_reg holds 4'b0100 and raw=0; then token_in_vec=2'b10 -> token_out_vec=proc_dep_vld_vec on the next cycle.
REQ-041 SHALL cover: origin=1 with token_clear=1 and proc_dep_vld_vec=3'b110 -> token_out_vec=3'b110 on the next cycle.
